// File: rtl/uart_pkg.sv
// uart_pkg: shared types for the UART transmit path.
// Holds the TX FIFO state encoding and the default byte width.
package uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_REQ  = 2'd2,
    ST_SEND = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: DEPTH x DATA_W byte storage, one write port and
// one read port addressed by a registered pointer. No reset on the array.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (read).
module uart_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  import uart_pkg::*;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a UART transmitter one frame at a time.
// Host side: wr_en/wr_data push, flush clears, ovf_clr clears sticky
// overflow/tx_err; status full/empty/overflow/tx_err/byte_sent.
// UART side: tx_data/tx_en out, tx_flag in (high = transmitter idle).
// Optional macro UART_TX_FIFO_LEVEL_EN adds level and almost_full outputs.
module uart_tx_fifo #(
  parameter int DATA_W  = uart_pkg::DATA_W,
  parameter int DEPTH   = 16,
  parameter int AW      = $clog2(DEPTH),
  parameter int TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              flush,
  input  logic              ovf_clr,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic              tx_err,
  output logic              byte_sent,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_en,
  input  logic              tx_flag
`ifdef UART_TX_FIFO_LEVEL_EN
  ,
  output logic [AW:0]       level,
  output logic              almost_full
`endif
);
  import uart_pkg::*;

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [15:0]   TMO_LAST = 16'(TIMEOUT - 1);

  tx_state_e state_q, state_d;

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              ovf_q, ovf_d;
  logic              err_q, err_d;
  logic              sent_q, sent_d;
  logic              en_q, en_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [15:0]       timer_q, timer_d;
  logic              sync1_q, flag_s_q;

  logic              push, pop, ovf_set, err_set;
  logic [DATA_W-1:0] rd_data;

  uart_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (wr_data),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  // A push while full is dropped even if a pop lands in the same cycle.
  assign push    = wr_en && !full_q && !flush;
  assign ovf_set = wr_en && full_q && !flush;
  assign pop     = (state_q == ST_LOAD);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CNT_ONE;
        2'b01:   cnt_d = cnt_q - CNT_ONE;
        default: cnt_d = cnt_q;
      endcase
    end
    full_d  = (cnt_d == CNT_FULL);
    empty_d = (cnt_d == '0);
    ovf_d   = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
    err_d   = err_set ? 1'b1 : (ovf_clr ? 1'b0 : err_q);
  end

  // tx_en is a registered view of "still in REQ next cycle", so it
  // rises one clock after REQ entry and falls on the exit edge.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    data_d  = data_q;
    en_d    = 1'b0;
    sent_d  = 1'b0;
    err_set = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // Don't start a load from a FIFO that is being flushed.
        if (!empty_q && flag_s_q && !flush) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        data_d  = rd_data;
        timer_d = '0;
        state_d = ST_REQ;
      end
      ST_REQ: begin
        timer_d = timer_q + 16'd1;
        if (!flag_s_q) begin
          state_d = ST_SEND;
        end else if (timer_q == TMO_LAST) begin
          err_set = 1'b1;
          state_d = ST_IDLE;
        end else begin
          en_d = 1'b1;
        end
      end
      ST_SEND: begin
        if (flag_s_q) begin
          sent_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      sent_q   <= 1'b0;
      en_q     <= 1'b0;
      data_q   <= '0;
      timer_q  <= '0;
      sync1_q  <= 1'b0;
      flag_s_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
      sent_q   <= sent_d;
      en_q     <= en_d;
      data_q   <= data_d;
      timer_q  <= timer_d;
      sync1_q  <= tx_flag;
      flag_s_q <= sync1_q;
    end
  end

  assign full      = full_q;
  assign empty     = empty_q;
  assign overflow  = ovf_q;
  assign tx_err    = err_q;
  assign byte_sent = sent_q;
  assign tx_data   = data_q;
  assign tx_en     = en_q;

`ifdef UART_TX_FIFO_LEVEL_EN
  localparam logic [AW:0] CNT_AF = (AW+1)'(DEPTH - 2);

  logic af_q, af_d;

  assign af_d = (cnt_d >= CNT_AF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) af_q <= 1'b0;
    else        af_q <= af_d;
  end

  assign level       = cnt_q;
  assign almost_full = af_q;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench with a queue model of the FIFO
// and a UART model; one negedge process compares against the model.
module tb_uart_tx_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int TMO   = 100;
  localparam int BIT   = 4;
  localparam int FRAME = 10 * BIT;
  localparam int M_NORM = 0;
  localparam int M_LOW  = 1;
  localparam int M_HIGH = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic          flush = 1'b0;
  logic          ovf_clr = 1'b0;
  logic          tx_flag = 1'b1;
  logic [DW-1:0] wr_data = '0;
  logic          full, empty, overflow, tx_err, byte_sent, tx_en;
  logic [DW-1:0] tx_data;
`ifdef UART_TX_FIFO_LEVEL_EN
  logic [AW:0]   level;
  logic          almost_full;
`endif

  int checks = 0;
  int errors = 0;
  int mode = M_NORM;

  uart_tx_fifo #(
    .DATA_W  (DW),
    .DEPTH   (DEPTH),
    .AW      (AW),
    .TIMEOUT (TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .flush     (flush),
    .ovf_clr   (ovf_clr),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .tx_err    (tx_err),
    .byte_sent (byte_sent),
    .tx_data   (tx_data),
    .tx_en     (tx_en),
    .tx_flag   (tx_flag)
`ifdef UART_TX_FIFO_LEVEL_EN
    ,
    .level       (level),
    .almost_full (almost_full)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Model state, written only by the compare process below.
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] rx_log[$];
  logic          m_ovf = 1'b0;
  logic          m_set = 1'b0;
  logic          prev_en = 1'b0;
  logic [DW-1:0] cur = '0;
  int busy = 0, age = 0, pend = 0, pend_age = 0, en_len = 0, bs_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_ovf = 1'b0;
      prev_en = 1'b0;
      busy = 0;
      pend = 0;
      en_len = 0;
      tx_flag = 1'b1;
    end else begin
      chk("overflow", int'(overflow), int'(m_ovf));
      if (tx_en && !prev_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_en_extra: data %0h, want no request", tx_data);
        end else begin
          chk("tx_data_order", int'(tx_data), int'(exp_q[0]));
          cur = exp_q.pop_front();
        end
        en_len = 0;
      end
      if (tx_en) en_len++;
      if (!tx_en && prev_en && mode == M_HIGH) begin
        chk("req_len", en_len, TMO - 1);
        chk("tx_err_at_timeout", int'(tx_err), 1);
      end
      prev_en = tx_en;
      if (byte_sent) begin
        bs_cnt++;
        chk("byte_sent_has_frame", int'(pend > 0), 1);
        if (pend > 0) pend--;
      end
      if (pend > 0) begin
        pend_age++;
        if (pend_age > 6) begin
          checks++;
          errors++;
          $display("FAIL byte_sent_late: %0d cycles, want <=6", pend_age);
          pend = 0;
        end
      end
      case (mode)
        M_LOW:  tx_flag = 1'b0;
        M_HIGH: tx_flag = 1'b1;
        default: begin
          if (busy != 0) begin
            chk("tx_data_stable", int'(tx_data), int'(cur));
            if (age >= 2) chk("tx_en_dropped", int'(tx_en), 0);
            age++;
            if (age == FRAME) begin
              busy = 0;
              tx_flag = 1'b1;
              pend++;
              pend_age = 0;
            end
          end else if (tx_en && tx_flag) begin
            busy = 1;
            age = 0;
            tx_flag = 1'b0;
            rx_log.push_back(tx_data);
          end else begin
            tx_flag = 1'b1;
          end
        end
      endcase
      m_set = wr_en && !flush && (exp_q.size() >= DEPTH);
      if (flush) exp_q.delete();
      else if (wr_en && !m_set) exp_q.push_back(wr_data);
      m_ovf = m_set ? 1'b1 : (ovf_clr ? 1'b0 : m_ovf);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] b);
    wr_en = 1'b1;
    wr_data = b;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic wait_en(input string nm, output int n);
    n = 0;
    while (!tx_en && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(nm, int'(tx_en), 1);
  endtask

  task automatic wait_idle(input string nm, input int lim);
    int q = 0;
    int n = 0;
    while (q < 8 && n < lim) begin
      @(posedge clk);
      #1;
      n++;
      if (empty && !tx_en && busy == 0 && pend == 0 && exp_q.size() == 0)
        q++;
      else
        q = 0;
    end
    if (q < 8) begin
      checks++;
      errors++;
      $display("FAIL %s: busy after %0d cycles, want idle", nm, lim);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not end, want end");
    $fatal(1);
  end

  initial begin
    int base, bs0, n;
    tick(3);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_tx_en", int'(tx_en), 0);
    chk("rst_tx_data", int'(tx_data), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_err", int'(tx_err), 0);
    chk("rst_sent", int'(byte_sent), 0);
    rst_n = 1'b1;
    tick(4);

    // three frames through the UART model, plus push-to-tx_en latency
    base = rx_log.size();
    bs0 = bs_cnt;
    push(8'h55);
    n = 0;
    while (!tx_en && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", n, 3);
    chk("first_tx_data", int'(tx_data), 'h55);
    push(8'hA3);
    push(8'h0F);
    wait_idle("t1_idle", 600);
    chk("t1_frames", rx_log.size() - base, 3);
    chk("t1_b0", int'(rx_log[base]), 'h55);
    chk("t1_b1", int'(rx_log[base+1]), 'hA3);
    chk("t1_b2", int'(rx_log[base+2]), 'h0F);
    chk("t1_sent", bs_cnt - bs0, 3);

    // fill to full with the transmitter held busy, 17th byte dropped
    mode = M_LOW;
    tick(4);
    base = rx_log.size();
    for (int i = 0; i < 17; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(8'h20 + i);
      @(posedge clk);
      #1;
      if (i == 14) chk("full_at_15", int'(full), 0);
      if (i == 15) chk("full_at_16", int'(full), 1);
    end
    wr_en = 1'b0;
    chk("ovf_set", int'(overflow), 1);
    chk("t2_not_empty", int'(empty), 0);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    chk("ovf_cleared", int'(overflow), 0);
    chk("t2_still_full", int'(full), 1);
    mode = M_NORM;
    wait_idle("t2_drain", 2000);
    chk("t2_frames", rx_log.size() - base, 16);
    chk("t2_first", int'(rx_log[base]), 'h20);
    chk("t2_last", int'(rx_log[base+15]), 'h2F);

    // pushes straddling the LOAD at count 5: one pop, count reaches 16
    mode = M_LOW;
    tick(4);
    base = rx_log.size();
    for (int i = 0; i < 5; i++) push(8'(8'h60 + i));
    mode = M_NORM;
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(8'h65 + i);
      @(posedge clk);
      #1;
      chk("t3_not_empty", int'(empty), 0);
    end
    wr_en = 1'b0;
    chk("t3_frame_running", busy, 1);
    for (int i = 0; i < 6; i++) begin
      push(8'(8'h6B + i));
      if (i == 4) chk("t3_full_at_15", int'(full), 0);
      if (i == 5) chk("t3_full_at_16", int'(full), 1);
    end
    chk("t3_no_ovf", int'(overflow), 0);
    wait_idle("t3_drain", 2500);
    chk("t3_frames", rx_log.size() - base, 17);
    chk("t3_first", int'(rx_log[base]), 'h60);
    chk("t3_last", int'(rx_log[base+16]), 'h70);

    // transmitter never accepts: timeout sets tx_err, byte discarded
    mode = M_HIGH;
    tick(2);
    push(8'h11);
    wait_en("t4_en", n);
    chk("t4_data", int'(tx_data), 'h11);
    n = 0;
    while (tx_en && n < TMO + 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("t4_en_low", int'(tx_en), 0);
    chk("t4_err", int'(tx_err), 1);
    chk("t4_empty", int'(empty), 1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    chk("t4_err_clr", int'(tx_err), 0);
    mode = M_NORM;
    tick(4);

    // flush during SEND with 4 queued; wr_en in flush cycle ignored
    mode = M_LOW;
    tick(4);
    base = rx_log.size();
    bs0 = bs_cnt;
    for (int i = 0; i < 5; i++) push(8'(8'h81 + i));
    mode = M_NORM;
    n = 0;
    while (busy == 0 && n < 30) begin
      tick(1);
      n++;
    end
    chk("t5_started", busy, 1);
    tick(10);
    flush = 1'b1;
    wr_en = 1'b1;
    wr_data = 8'h99;
    tick(1);
    flush = 1'b0;
    wr_en = 1'b0;
    chk("t5_empty", int'(empty), 1);
    wait_idle("t5_idle", 500);
    chk("t5_frames", rx_log.size() - base, 1);
    chk("t5_byte", int'(rx_log[base]), 'h81);
    chk("t5_sent", bs_cnt - bs0, 1);
    tick(20);
    chk("t5_quiet", int'(tx_en), 0);

    // asynchronous reset while in REQ
    mode = M_HIGH;
    tick(2);
    push(8'h42);
    push(8'h43);
    wait_en("t6_in_req", n);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_tx_en", int'(tx_en), 0);
    chk("t6_empty", int'(empty), 1);
    chk("t6_full", int'(full), 0);
    chk("t6_ovf", int'(overflow), 0);
    chk("t6_err", int'(tx_err), 0);
    chk("t6_sent", int'(byte_sent), 0);
    chk("t6_tx_data", int'(tx_data), 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    mode = M_NORM;
    tick(10);
    chk("t6_after_en", int'(tx_en), 0);
    chk("t6_after_empty", int'(empty), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
